usb_serial_tx_fifo: RTL and testbench
=====================================

USB_SERIAL_TX_FIFO -- requirements
Module: usb_serial_tx_fifo

Interface
REQ-001 SHALL have parameter Depth, default 16, meaning byte entries stored; power of two, at least 2.
REQ-002 SHALL have parameter DepthW, default $clog2(Depth), meaning pointer index width.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clr_i  input  1  synchronous flush of contents and sticky flags.
REQ-006 SHALL have port wvalid_i  input  1  producer offers wdata_i this cycle.
REQ-007 SHALL have port wdata_i  input  8  byte to enqueue.
REQ-008 SHALL have port wready_o  output  1  FIFO can accept a byte (not full).
REQ-009 SHALL have port tx_read  input  1  USB serial endpoint pops the head byte this cycle.
REQ-010 SHALL have port tx_empty  output  1  no byte stored.
REQ-011 SHALL have port tx_fifo_rdata  output  8  head byte, first-word-fall-through.
REQ-012 SHALL have port depth_o  output  DepthW+1  current occupancy, 0..Depth.
REQ-013 SHALL have port overflow_o  output  1  sticky: push attempted while full.
REQ-014 SHALL have port underflow_o  output  1  sticky: pop attempted while empty.

Function
REQ-015 SHALL hold write and read pointers of DepthW+1 bits; the low DepthW bits index storage, and the MSB is a wrap bit.
REQ-016 SHALL flag empty when the pointers are equal, and full when the low bits are equal and the MSBs differ.
REQ-017 SHALL drive wready_o = !full, independent of tx_read in the same cycle (no pass-through when full).
REQ-018 SHALL accept a push when wvalid_i && wready_o: store wdata_i at wptr and increment wptr modulo 2^(DepthW+1).
REQ-019 SHALL accept a pop when tx_read && !tx_empty: increment rptr.
REQ-020 SHALL drive tx_fifo_rdata combinationally from storage[rptr] whenever !tx_empty, so it is valid in the same cycle tx_read is sampled; its value is don't-care when empty.
REQ-021 SHALL make a pushed byte visible on tx_fifo_rdata, with tx_empty low, in the cycle after the push (1-cycle write-to-read latency).
REQ-022 SHALL, on a simultaneous push and pop with 0 < depth < Depth, do both; occupancy is unchanged.
REQ-023 SHALL, on a simultaneous push and pop when empty, accept the push, ignore the pop and set underflow_o.
REQ-024 SHALL, on wvalid_i while full, drop the byte, leave storage unchanged and set overflow_o; a pop in the same cycle still completes.
REQ-025 SHALL drive depth_o = wptr - rptr in DepthW+1-bit arithmetic, registered-pointer based with no extra latency.
REQ-026 SHALL give clr_i priority over push and pop: next cycle pointers are 0, tx_empty=1, and both sticky flags are 0; storage contents are not cleared.
REQ-027 SHALL hold overflow_o and underflow_o set until clr_i or rst_i.
REQ-028 SHALL preserve ordering: bytes leave in exact push order across pointer wrap-around.

Reset
REQ-029 SHALL, on rst_i asserted, asynchronously force wptr=0, rptr=0, overflow_o=0 and underflow_o=0, giving tx_empty=1, wready_o=1 and depth_o=0.
REQ-030 SHALL not reset the storage array; tx_fifo_rdata is don't-care while empty.
REQ-031 SHALL ignore push and pop while rst_i is high; reset asserted mid-operation discards all stored bytes.

Structure
REQ-032 SHALL place the default depth constant (UsbSerialFifoDepth = 16) in the shared usb_serial_pkg package, used by both the tx and rx FIFO instances.
REQ-033 SHALL be a single flat module with no sub-module; the pointer, flag and storage logic is too small to justify splitting.
REQ-034 SHALL infer storage as a register array with no memory macro.

Verification
REQ-035 SHALL cover: reset, then push 0xA5 -> next cycle tx_empty=0, tx_fifo_rdata=0xA5, depth_o=1; tx_read -> next cycle tx_empty=1.
REQ-036 SHALL cover: push 16 bytes 0x00..0x0F -> wready_o=0, depth_o=16; push 0xFF -> overflow_o=1, and 16 pops return 0x00..0x0F in order.
REQ-037 SHALL cover: tx_read asserted while empty -> underflow_o=1, pointers unchanged; clr_i -> underflow_o=0.
REQ-038 SHALL cover: fill to 8, then 40 cycles of simultaneous push/pop with an incrementing pattern -> depth_o stays 8, output sequence is continuous, and pointers wrap correctly.
REQ-039 SHALL cover: 5 bytes stored, clr_i and wvalid_i together -> next cycle depth_o=0 and tx_empty=1 (the push is discarded).
REQ-040 SHALL cover: rst_i pulsed asynchronously mid-burst with 3 bytes stored -> tx_empty=1 immediately with no clock edge, and depth_o=0.

Source files
------------

// File: rtl/usb_serial_pkg.sv
// Shared constants for the USB serial tx/rx byte FIFOs.
package usb_serial_pkg;

    // Default number of byte entries in each serial FIFO instance.
    localparam int UsbSerialFifoDepth = 16;

    // One byte of serial payload.
    typedef logic [7:0] usb_byte_t;

endpackage : usb_serial_pkg

// File: rtl/usb_serial_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the USB serial transmit endpoint.
// Wrap-bit pointers give full/empty without a separate counter; sticky
// overflow/underflow flags record misuse until cleared.
module usb_serial_tx_fifo
    import usb_serial_pkg::*;
#(
    parameter int Depth  = UsbSerialFifoDepth,
    parameter int DepthW = $clog2(Depth)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              wvalid_i,
    input  logic [7:0]        wdata_i,
    output logic              wready_o,
    input  logic              tx_read,
    output logic              tx_empty,
    output logic [7:0]        tx_fifo_rdata,
    output logic [DepthW:0]   depth_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [DepthW:0] PtrOne = {{DepthW{1'b0}}, 1'b1};

    // Storage is never reset; its contents only matter between rptr and wptr.
    usb_byte_t mem_reg [Depth];

    logic [DepthW:0] wptr_reg, wptr_next;
    logic [DepthW:0] rptr_reg, rptr_next;
    logic            overflow_reg, overflow_next;
    logic            underflow_reg, underflow_next;

    logic full;
    logic empty;
    logic push_en;
    logic pop_en;

    // Equal pointers mean empty; equal index with differing wrap bits means full.
    assign empty = (wptr_reg == rptr_reg);
    assign full  = (wptr_reg[DepthW-1:0] == rptr_reg[DepthW-1:0]) &&
                   (wptr_reg[DepthW] != rptr_reg[DepthW]);

    // wready depends only on stored state, so a pop cannot make room for a
    // push in the same cycle.
    assign push_en = wvalid_i && !full;
    assign pop_en  = tx_read && !empty;

    assign wready_o      = !full;
    assign tx_empty      = empty;
    assign tx_fifo_rdata = mem_reg[rptr_reg[DepthW-1:0]];
    assign depth_o       = wptr_reg - rptr_reg;
    assign overflow_o    = overflow_reg;
    assign underflow_o   = underflow_reg;

    // Next-state for pointers and sticky flags; clear overrides push and pop.
    always_comb begin
        wptr_next      = wptr_reg;
        rptr_next      = rptr_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        if (clr_i) begin
            wptr_next      = '0;
            rptr_next      = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else begin
            if (push_en) begin
                wptr_next = wptr_reg + PtrOne;
            end
            if (pop_en) begin
                rptr_next = rptr_reg + PtrOne;
            end
            if (wvalid_i && full) begin
                overflow_next = 1'b1;
            end
            if (tx_read && empty) begin
                underflow_next = 1'b1;
            end
        end
    end

    // Pointer and flag registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Byte storage write; a push swallowed by clear or reset leaves it untouched.
    always_ff @(posedge clk_i) begin
        if (push_en && !clr_i && !rst_i) begin
            mem_reg[wptr_reg[DepthW-1:0]] <= wdata_i;
        end
    end

endmodule : usb_serial_tx_fifo

// File: tb/tb_usb_serial_tx_fifo.sv
// Self-checking bench for usb_serial_tx_fifo: a vector table, directed
// multi-cycle sequences, and randomized traffic against a queue model.
module tb_usb_serial_tx_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = $clog2(DEPTH);

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          clr_i;
    logic          wvalid_i;
    logic [7:0]    wdata_i;
    logic          wready_o;
    logic          tx_read;
    logic          tx_empty;
    logic [7:0]    tx_fifo_rdata;
    logic [DW:0]   depth_o;
    logic          overflow_o;
    logic          underflow_o;

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue plus the two sticky flags.
    logic [7:0] model_q[$];
    bit         model_ovf;
    bit         model_unf;

    usb_serial_tx_fifo #(.Depth(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (clr_i),
        .wvalid_i     (wvalid_i),
        .wdata_i      (wdata_i),
        .wready_o     (wready_o),
        .tx_read      (tx_read),
        .tx_empty     (tx_empty),
        .tx_fifo_rdata(tx_fifo_rdata),
        .depth_o      (depth_o),
        .overflow_o   (overflow_o),
        .underflow_o  (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit         wv;
        logic [7:0] wd;
        bit         rd;
        bit         clr;
        bit         exp_empty;
        int         exp_depth;
        logic [7:0] exp_rdata;
        bit         exp_ovf;
        bit         exp_unf;
        bit         exp_wready;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply the FIFO rules to the model for one clock edge.
    task automatic model_step(input bit wv, input logic [7:0] wd, input bit rd, input bit clr);
        bit was_full;
        bit was_empty;
        if (clr) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end else begin
            was_full  = (model_q.size() == DEPTH);
            was_empty = (model_q.size() == 0);
            if (wv && was_full)  model_ovf = 1'b1;
            if (rd && was_empty) model_unf = 1'b1;
            if (rd && !was_empty) void'(model_q.pop_front());
            if (wv && !was_full) model_q.push_back(wd);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
    endtask

    // Drive one cycle, let the edge pass, update the model, return inputs to idle.
    task automatic cycle(input bit wv, input logic [7:0] wd, input bit rd, input bit clr);
        wvalid_i = wv;
        wdata_i  = wd;
        tx_read  = rd;
        clr_i    = clr;
        @(posedge clk_i);
        #1;
        model_step(wv, wd, rd, clr);
        wvalid_i = 1'b0;
        tx_read  = 1'b0;
        clr_i    = 1'b0;
        $display("txn wv=%0d wd=%02h rd=%0d clr=%0d -> empty=%0d depth=%0d rdata=%02h ovf=%0d unf=%0d",
                 wv, wd, rd, clr, tx_empty, depth_o, tx_fifo_rdata, overflow_o, underflow_o);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".empty"},  32'(tx_empty),    32'(model_q.size() == 0));
        chk({tag, ".depth"},  32'(depth_o),     32'(model_q.size()));
        chk({tag, ".wready"}, 32'(wready_o),    32'(model_q.size() < DEPTH));
        chk({tag, ".ovf"},    32'(overflow_o),  32'(model_ovf));
        chk({tag, ".unf"},    32'(underflow_o), 32'(model_unf));
        if (model_q.size() != 0) begin
            chk({tag, ".rdata"}, 32'(tx_fifo_rdata), 32'(model_q[0]));
        end
    endtask

    initial begin
        logic [7:0] nxt;
        rst_i    = 1'b1;
        clr_i    = 1'b0;
        wvalid_i = 1'b0;
        wdata_i  = 8'h00;
        tx_read  = 1'b0;
        model_reset();

        // Hold reset for two edges, release it away from the edge.
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("reset.empty",  32'(tx_empty),    32'd1);
        chk("reset.wready", 32'(wready_o),    32'd1);
        chk("reset.depth",  32'(depth_o),     32'd0);
        chk("reset.ovf",    32'(overflow_o),  32'd0);
        chk("reset.unf",    32'(underflow_o), 32'd0);

        // Vector table: single push/pop, underflow, simultaneous ops, clear.
        //            wv  wd    rd clr  empty depth rdata ovf unf wready
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1, 8'h11, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1, 8'h22, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1, 8'h33, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 2, 8'h33, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].wv, tbl[i].wd, tbl[i].rd, tbl[i].clr);
            chk($sformatf("vec%0d.empty", i),  32'(tx_empty),    32'(tbl[i].exp_empty));
            chk($sformatf("vec%0d.depth", i),  32'(depth_o),     32'(tbl[i].exp_depth));
            chk($sformatf("vec%0d.ovf", i),    32'(overflow_o),  32'(tbl[i].exp_ovf));
            chk($sformatf("vec%0d.unf", i),    32'(underflow_o), 32'(tbl[i].exp_unf));
            chk($sformatf("vec%0d.wready", i), 32'(wready_o),    32'(tbl[i].exp_wready));
            if (!tbl[i].exp_empty) begin
                chk($sformatf("vec%0d.rdata", i), 32'(tx_fifo_rdata), 32'(tbl[i].exp_rdata));
            end
        end

        // Fill to full, overflow, then drain in order.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        chk("full.wready", 32'(wready_o), 32'd0);
        chk("full.depth",  32'(depth_o),  32'(DEPTH));
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("full.ovf",    32'(overflow_o), 32'd1);
        chk("full.depth2", 32'(depth_o),    32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d.rdata", i), 32'(tx_fifo_rdata), 32'(i));
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain.empty", 32'(tx_empty), 32'd1);
        chk("drain.ovf",   32'(overflow_o), 32'd1);

        // Full with push and pop together: pop completes, push is dropped.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("fullpp.depth", 32'(depth_o),       32'(DEPTH - 1));
        chk("fullpp.rdata", 32'(tx_fifo_rdata), 32'h41);
        check_model("fullpp");

        // Underflow on empty, then clear drops the flag.
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf.set",   32'(underflow_o), 32'd1);
        chk("unf.depth", 32'(depth_o),     32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("unf.clr",   32'(underflow_o), 32'd0);

        // Fill to 8, then 40 cycles of simultaneous push/pop across wrap.
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("stream%0d.rdata", i), 32'(tx_fifo_rdata), 32'(i));
            cycle(1'b1, 8'(i + 8), 1'b1, 1'b0);
            chk($sformatf("stream%0d.depth", i), 32'(depth_o), 32'd8);
        end

        // Clear together with a push: push discarded.
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 1'b0, 1'b1);
        chk("clrpush.depth", 32'(depth_o),  32'd0);
        chk("clrpush.empty", 32'(tx_empty), 32'd1);

        // Asynchronous reset mid-burst with 3 bytes stored.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        chk("pre_rst.depth", 32'(depth_o), 32'd3);
        wvalid_i = 1'b1;
        wdata_i  = 8'h77;
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst.empty", 32'(tx_empty), 32'd1);
        chk("arst.depth", 32'(depth_o),  32'd0);
        @(posedge clk_i);
        #1;
        chk("arst_hold.empty", 32'(tx_empty), 32'd1);
        rst_i    = 1'b0;
        wvalid_i = 1'b0;
        model_reset();
        check_model("post_rst");

        // Randomized traffic in phases biased toward full, empty and balanced.
        for (int ph = 0; ph < 4; ph++) begin
            int pw;
            int pr;
            pw = (ph == 0) ? 80 : (ph == 1) ? 30 : (ph == 2) ? 60 : 50;
            pr = (ph == 0) ? 30 : (ph == 1) ? 80 : (ph == 2) ? 60 : 50;
            for (int c = 0; c < 100; c++) begin
                bit wv;
                bit rd;
                bit clr;
                wv  = ($urandom_range(0, 99) < pw);
                rd  = ($urandom_range(0, 99) < pr);
                clr = ($urandom_range(0, 199) == 0);
                nxt = 8'($urandom);
                cycle(wv, nxt, rd, clr);
                check_model($sformatf("rnd%0d_%0d", ph, c));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_usb_serial_tx_fifo
